// File: rtl/q_edge_monitor.sv
// Edge monitor for a flip-flop output: one-cycle rise/fall pulses, saturating event counters and last high-pulse length.
// Build option Q_EDGE_MONITOR_SYNC_EN inserts a two-flop synchronizer ahead of the sample register.
//
// state | meaning
// IDLE  | after reset, waiting for the input pipeline to fill
// LOW   | last sampled level was 0
// HIGH  | last sampled level was 1, width counter running
module q_edge_monitor #(
  parameter int CNT_W = 8,
  parameter int LEN_W = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Q_in,
  input  logic             Clear,
  output logic             Rise_pulse,
  output logic             Fall_pulse,
  output logic [CNT_W-1:0] Rise_count,
  output logic [CNT_W-1:0] Fall_count,
  output logic [LEN_W-1:0] High_len,
  output logic             Len_valid,
  output logic             Overflow,
  output logic             Armed
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

  state_t           state_q, state_d;
  logic             s_q;
  logic [1:0]       arm_cnt_q, arm_cnt_d;
  logic [LEN_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d, rise_base;
  logic [CNT_W-1:0] fall_cnt_q, fall_cnt_d, fall_base;
  logic [LEN_W-1:0] high_len_q, high_len_d;
  logic             ovf_q, ovf_d;
  logic             rise_pulse_q, fall_pulse_q, len_valid_q, armed_q;
  logic             rise_det, fall_det, arm_inc, width_inc;
  logic             rise_sat, fall_sat, width_sat;

`ifdef Q_EDGE_MONITOR_SYNC_EN
  localparam logic [1:0] ARM_LAST = 2'd3;
  logic [1:0] sync_q;

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      sync_q <= '0;
      s_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], Q_in};
      s_q    <= sync_q[1];
    end
  end
`else
  localparam logic [1:0] ARM_LAST = 2'd1;

  always_ff @(posedge CLK) begin
    if (!Reset) s_q <= 1'b0;
    else        s_q <= Q_in;
  end
`endif

  always_ff @(posedge CLK) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Arming picks the initial level silently so the reset level never looks like an edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arm_cnt_q == ARM_LAST) state_d = s_q ? HIGH : LOW;
      LOW:     if (s_q)  state_d = HIGH;
      HIGH:    if (!s_q) state_d = LOW;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rise_det  = (state_q == LOW)  &&  s_q;
    fall_det  = (state_q == HIGH) && !s_q;
    width_inc = (state_q == HIGH) &&  s_q;
    arm_inc   = (state_q == IDLE);
  end

  // Clear is applied before a same-cycle edge, so that edge counts as the first event.
  always_comb begin
    arm_cnt_d = arm_cnt_q;
    if (arm_inc && (arm_cnt_q != ARM_LAST)) arm_cnt_d = arm_cnt_q + 2'd1;

    width_d   = width_q;
    width_sat = 1'b0;
    if (rise_det) begin
      width_d = LEN_W'(1);
    end else if (width_inc) begin
      if (width_q == LEN_MAX) width_sat = 1'b1;
      else                    width_d   = width_q + LEN_W'(1);
    end

    rise_base  = Clear ? '0 : rise_cnt_q;
    rise_cnt_d = rise_base;
    rise_sat   = 1'b0;
    if (rise_det) begin
      if (rise_base == CNT_MAX) rise_sat   = 1'b1;
      else                      rise_cnt_d = rise_base + CNT_W'(1);
    end

    fall_base  = Clear ? '0 : fall_cnt_q;
    fall_cnt_d = fall_base;
    fall_sat   = 1'b0;
    if (fall_det) begin
      if (fall_base == CNT_MAX) fall_sat   = 1'b1;
      else                      fall_cnt_d = fall_base + CNT_W'(1);
    end

    high_len_d = Clear ? '0 : high_len_q;
    if (fall_det) high_len_d = width_q;

    ovf_d = (Clear ? 1'b0 : ovf_q) | rise_sat | fall_sat | width_sat;
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      arm_cnt_q    <= '0;
      width_q      <= '0;
      rise_cnt_q   <= '0;
      fall_cnt_q   <= '0;
      high_len_q   <= '0;
      ovf_q        <= 1'b0;
      rise_pulse_q <= 1'b0;
      fall_pulse_q <= 1'b0;
      len_valid_q  <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      arm_cnt_q    <= arm_cnt_d;
      width_q      <= width_d;
      rise_cnt_q   <= rise_cnt_d;
      fall_cnt_q   <= fall_cnt_d;
      high_len_q   <= high_len_d;
      ovf_q        <= ovf_d;
      rise_pulse_q <= rise_det;
      fall_pulse_q <= fall_det;
      len_valid_q  <= fall_det;
      armed_q      <= (state_d != IDLE);
    end
  end

  assign Rise_pulse = rise_pulse_q;
  assign Fall_pulse = fall_pulse_q;
  assign Rise_count = rise_cnt_q;
  assign Fall_count = fall_cnt_q;
  assign High_len   = high_len_q;
  assign Len_valid  = len_valid_q;
  assign Overflow   = ovf_q;
  assign Armed      = armed_q;

endmodule
